// File: rtl/div_if.sv
// div_if: operand/handshake bundle between EX and the divider.
// EX drives operands and start/annul; the divider returns result/ready.
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div.sv
// div: iterative 32-bit restoring divider for DIV/DIVU.
// One quotient bit per cycle; result is {remainder, quotient}.
module div #(
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_dividend;
   logic [31:0] r_divisor;
   logic [63:0] r_result;
   logic        r_ready;

   logic [31:0] w_op1;
   logic [31:0] w_op2;
   logic [32:0] w_diff;
   logic        w_neg_q;
   logic        w_neg_r;
   logic [31:0] w_q;
   logic [31:0] w_r;

   // Magnitudes for signed division; 0x80000000 stays as unsigned 2^31.
   assign w_op1 = (bus.signed_div_i && bus.opdata1_i[31])
                ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
   assign w_op2 = (bus.signed_div_i && bus.opdata2_i[31])
                ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

   // Trial subtraction; bit 32 is the borrow.
   assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

   // Quotient sign from operand signs, remainder follows the dividend.
   assign w_neg_q = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
   assign w_neg_r = bus.signed_div_i & bus.opdata1_i[31];
   assign w_q = w_neg_q ? (~r_dividend[31:0] + 32'd1) : r_dividend[31:0];
   assign w_r = w_neg_r ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

   // Sequencer: accept, step 32 times, fix signs, hold until start drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FREE;
         r_cnt      <= 6'd0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_result   <= '0;
         r_ready    <= 1'b0;
      end else begin
         unique case (r_state)
            S_FREE: begin
               r_ready  <= 1'b0;
               r_result <= '0;
               if (bus.start_i && !bus.annul_i) begin
                  if (bus.opdata2_i == 32'd0) begin
                     r_state <= S_BYZERO;
                  end else begin
                     r_state    <= S_ON;
                     r_cnt      <= 6'd0;
                     r_dividend <= {32'b0, w_op1, 1'b0};
                     r_divisor  <= w_op2;
                  end
               end
            end
            S_BYZERO: begin
               r_dividend <= '0;
               r_result   <= '0;
               r_ready    <= 1'b1;
               r_state    <= S_END;
            end
            S_ON: begin
               if (bus.annul_i) begin
                  r_state <= S_FREE;
                  r_cnt   <= 6'd0;
               end else if (r_cnt != 6'd32) begin
                  if (w_diff[32])
                     r_dividend <= {r_dividend[63:0], 1'b0};
                  else
                     r_dividend <= {w_diff[31:0], r_dividend[31:0], 1'b1};
                  r_cnt <= r_cnt + 6'd1;
               end else begin
                  r_result <= {w_r, w_q};
                  r_ready  <= 1'b1;
                  r_state  <= S_END;
                  r_cnt    <= 6'd0;
               end
            end
            S_END: begin
               if (!bus.start_i) begin
                  r_state  <= S_FREE;
                  r_ready  <= 1'b0;
                  r_result <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// tb_div: table vectors, corner sequences and random operands
// checked against an arithmetic reference for the divider.
module tb_div;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   div_if bus ();

   div u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   // Reference: plain integer division, remainder signed like dividend.
   function automatic logic [63:0] model(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Wait for ready with a bound; returns edge count or 0 on timeout.
   task automatic wait_ready(output int n);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.ready_o === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string nm, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      int n;
      int lat;
      lat = (b == 32'd0) ? 2 : 34;
      bus.signed_div_i = s;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      wait_ready(n);
      chk({nm, "_lat"}, 64'(n), 64'(lat));
      chk({nm, "_res"}, bus.result_o, exp);
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0;
      chk({nm, "_hold"}, {bus.result_o, 63'd0} | 64'(bus.ready_o),
          {exp, 63'd0} | 64'd1);
      bus.start_i = 1'b0;
      tick();
      chk({nm, "_drop"}, bus.result_o | 64'(bus.ready_o), 64'd0);
   endtask

   vec_t vecs[9];

   initial begin
      int n;
      bit seen;
      logic        s;
      logic [31:0] a, b;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
      vecs[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000};
      vecs[5] = '{1'b0, 32'h00001234,   32'd0,        64'h0};
      vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E};
      vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
      vecs[8] = '{1'b1, 32'h80000000,   32'd0,        64'h0};

      rst = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      tick();
      tick();
      chk("reset", bus.result_o | 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a,
                vecs[i].b, vecs[i].exp);

      // Annul at step 10 of ON, then verify no ready appears.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd100;
      bus.opdata2_i    = 32'd7;
      bus.start_i      = 1'b1;
      tick();
      repeat (10) tick();
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.ready_o !== 1'b0) seen = 1'b1;
         tick();
      end
      chk("annul_noready", 64'(seen), 64'd0);
      run_op("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

      // Reset at step 20; start stays high so the op restarts from accept.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd100;
      bus.opdata2_i    = 32'd7;
      bus.start_i      = 1'b1;
      tick();
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("midrst", bus.result_o | 64'(bus.ready_o), 64'd0);
      rst = 1'b0;
      wait_ready(n);
      chk("midrst_lat", 64'(n), 64'd34);
      chk("midrst_res", bus.result_o, 64'h00000002_0000000E);
      bus.start_i = 1'b0;
      tick();
      chk("midrst_drop", bus.result_o | 64'(bus.ready_o), 64'd0);

      // Random operands against the reference.
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom();
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'(1 + $urandom_range(0, 15));
            2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            default: b = $urandom();
         endcase
         run_op($sformatf("rnd%0d", i), s, a, b, model(s, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative 32-bit integer divider sequencer for the EX stage. It serves the DIV/DIVU instructions.
- EX holds start_i high and stalls the pipeline until ready_o rises.
- The 64-bit {remainder, quotient} result is then forwarded to the EX/MEM register as the HI/LO write data.
- One restoring-division step per cycle, controlled by a 4-state FSM. Supports cancellation (annul_i) when the instruction is flushed.

Parameters:
- DATA_W, 32, operand width (fixed; the counter and state widths below assume 32)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset (sampled on rising edge of clk; `RstEnable = 1)
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  division request; EX holds it high until ready_o is seen
- annul_i  input  1  cancel the operation in progress (pipeline flush)
- result_o  output  64  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid; stays high while start_i remains high

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-division):
  - state=FREE, cnt=0, dividend=0, divisor=0
  - result_o=0, ready_o=0
  - rst has priority over every other input.
- Internal registers:
  - state[1:0]: FREE=0, BYZERO=1, ON=2, END=3
  - cnt[5:0]
  - dividend[64:0]: upper half holds the partial remainder, lower half holds quotient bits
  - divisor[31:0]
  - Captured operands temp_op1 and temp_op2: absolute values when signed_div_i=1 and the sign bit is set, else raw.
  - Abs of 0x80000000 is 0x80000000, treated as unsigned 2^31.
- FREE:
  - start_i=1 and annul_i=0, opdata2_i==0: go to BYZERO.
  - start_i=1 and annul_i=0, opdata2_i!=0: go to ON with cnt=0, dividend={32'b0, temp_op1, 1'b0}, divisor=temp_op2.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge sets dividend=0, result_o=0, ready_o=1, state=END. No exception is raised.
- ON with annul_i=1: go to FREE, cnt=0, ready_o stays 0. annul_i takes effect on any cycle of ON.
- ON with annul_i=0 and cnt!=32, one step per edge:
  - diff[32:0] = {1'b0, dividend[63:32]} - {1'b0, divisor}
  - diff[32]=1 (borrow): dividend = {dividend[63:0], 1'b0}
  - diff[32]=0: dividend = {diff[31:0], dividend[31:0], 1'b1}
  - cnt = cnt + 1
- ON with annul_i=0 and cnt==32 (sign fixup):
  - q = dividend[31:0], negated (two's complement) if signed_div_i & (opdata1_i[31] ^ opdata2_i[31]).
  - r = dividend[64:33], negated if signed_div_i & opdata1_i[31]. The remainder takes the sign of the dividend.
  - Same edge: result_o={r,q}, ready_o=1, state=END, cnt=0.
- Operand stability: opdata1_i, opdata2_i and signed_div_i must stay stable from start until ready_o. The fixup re-reads the input sign bits; EX guarantees stability by stalling.
- Latency, counted in edges including the one that samples start_i in FREE:
  - Normal division: 34 edges to ready_o=1 (1 accept + 32 steps + 1 fixup).
  - Divide by zero: 2 edges.
- END:
  - start_i=1: hold result_o and ready_o=1.
  - start_i=0: go to FREE with ready_o=0 and result_o=0.
  - annul_i is ignored in END.
- start_i dropping during ON does not abort the operation; only annul_i or rst does.
- Back-to-back operations: a new start_i is accepted only from FREE. After END there is at least one idle cycle with start_i=0.

Test Plan:
- Unsigned 100/7: signed_div_i=0, op1=100, op2=7, start_i held. Required: ready_o=1 exactly 34 edges after the start edge, result_o=0x00000002_0000000E. After start_i drops: ready_o=0, result_o=0 next edge.
- Signed -7/2: op1=0xFFFFFFF9, op2=2, signed. Required: result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Signed 7/-2: result_o=0x00000001_FFFFFFFD.
- Signed overflow corner: op1=0x80000000, op2=0xFFFFFFFF, signed. Required: q=0x80000000, r=0. Unsigned, same operands: q=0, r=0x80000000.
- Divide by zero: op1=0x1234, op2=0, start. Required: ready_o=1 after 2 edges, result_o=0, held until start_i=0.
- Annul at step 10 of ON: annul_i=1 for one cycle. Required: FREE next edge, ready_o never asserts. A fresh 100/7 then completes correctly in 34 edges.
- Reset mid-operation: rst=1 at step 20. Required: result_o=0, ready_o=0, state FREE on that edge. Operation is not resumed after rst falls, even with start_i still high; it restarts from accept.
